// File: rtl/ucsbece154_icache_cwf_if.sv
// Fetch-side and SDRAM-side signals of the critical-word-first instruction cache.
// The master modport is the environment (core plus SDRAM controller); the slave modport is the cache.
interface ucsbece154_icache_cwf_if;
    logic        ReadEnable;
    logic [31:0] ReadAddress;
    logic [31:0] Instruction;
    logic        Ready;
    logic        Busy;
    logic [31:0] MemReadAddress;
    logic        MemReadRequest;
    logic [31:0] MemDataIn;
    logic        MemDataReady;

    modport master (
        output ReadEnable, ReadAddress, MemDataIn, MemDataReady,
        input  Instruction, Ready, Busy, MemReadAddress, MemReadRequest
    );

    modport slave (
        input  ReadEnable, ReadAddress, MemDataIn, MemDataReady,
        output Instruction, Ready, Busy, MemReadAddress, MemReadRequest
    );
endinterface

// File: rtl/ucsbece154_icache_cwf.sv
// Set-associative read-only instruction cache with critical-word-first fill, early restart
// and a selectable victim policy (per-set round-robin or global LFSR).
module ucsbece154_icache_cwf #(
    parameter int NUM_SETS    = 8,
    parameter int NUM_WAYS    = 4,
    parameter int BLOCK_WORDS = 4,
    parameter int REPL_POLICY = 0
) (
    input logic Clk,
    input logic Reset,
    ucsbece154_icache_cwf_if.slave bus
);
    localparam int OB = $clog2(BLOCK_WORDS);
    localparam int SB = $clog2(NUM_SETS);
    localparam int WB = $clog2(NUM_WAYS);
    localparam int TB = 32 - OB - SB - 2;
    localparam logic [OB:0] LAST_BEAT = (OB+1)'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t state_q, state_d;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [TB-1:0]       tag_q   [NUM_SETS][NUM_WAYS];
    logic [31:0]         data_q  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
    logic [WB-1:0]       rrPtr_q [NUM_SETS];
    logic [15:0]         lfsr_q;

    logic [OB:0]   beatCnt_q, beatCnt_d;
    logic [TB-1:0] missTag_q;
    logic [SB-1:0] missSet_q;
    logic [OB-1:0] missWord_q;
    logic [WB-1:0] victim_q;

    logic [31:0] instr_q, instr_d;
    logic [31:0] memAddr_q, memAddr_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        memReq_q, memReq_d;

    logic [OB-1:0] reqWord;
    logic [SB-1:0] reqSet;
    logic [TB-1:0] reqTag;
    logic          hit;
    logic [WB-1:0] hitWay;
    logic [WB-1:0] victim;
    logic          missLatch, beatWrite, fillDone;
    logic [OB-1:0] fillOffset;
    logic [15:0]   lfsrNext;

    assign reqWord    = bus.ReadAddress[OB+1:2];
    assign reqSet     = bus.ReadAddress[OB+SB+1:OB+2];
    assign reqTag     = bus.ReadAddress[31:OB+SB+2];
    assign fillOffset = missWord_q + beatCnt_q[OB-1:0];
    assign lfsrNext   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    assign bus.Instruction    = instr_q;
    assign bus.Ready          = ready_q;
    assign bus.Busy           = busy_q;
    assign bus.MemReadAddress = memAddr_q;
    assign bus.MemReadRequest = memReq_q;

    always_comb begin
        hit    = 1'b0;
        hitWay = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (valid_q[reqSet][i] && (tag_q[reqSet][i] == reqTag)) begin
                hit    = 1'b1;
                hitWay = WB'(i);
            end
        end
    end

    // Descending scan so the lowest-index invalid way overrides the policy choice.
    always_comb begin
        victim = (REPL_POLICY == 1) ? lfsr_q[WB-1:0] : rrPtr_q[reqSet];
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_q[reqSet][i]) begin
                victim = WB'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        ready_d   = 1'b0;
        busy_d    = busy_q;
        memReq_d  = memReq_q;
        memAddr_d = memAddr_q;
        beatCnt_d = beatCnt_q;
        missLatch = 1'b0;
        beatWrite = 1'b0;
        fillDone  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ReadEnable) begin
                    if (hit) begin
                        ready_d = 1'b1;
                        instr_d = data_q[reqSet][hitWay][reqWord];
                    end else begin
                        busy_d    = 1'b1;
                        memReq_d  = 1'b1;
                        memAddr_d = {bus.ReadAddress[31:2], 2'b00};
                        beatCnt_d = '0;
                        missLatch = 1'b1;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.MemDataReady) begin
                    memReq_d  = 1'b0;
                    beatWrite = 1'b1;
                    instr_d   = bus.MemDataIn;
                    ready_d   = 1'b1;
                    beatCnt_d = beatCnt_q + 1'b1;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (bus.MemDataReady) begin
                    beatWrite = 1'b1;
                    beatCnt_d = beatCnt_q + 1'b1;
                    if (beatCnt_q == LAST_BEAT) begin
                        fillDone  = 1'b1;
                        busy_d    = 1'b0;
                        beatCnt_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            memReq_q  <= 1'b0;
            memAddr_q <= '0;
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            memReq_q  <= memReq_d;
            memAddr_q <= memAddr_d;
            beatCnt_q <= beatCnt_d;
        end
    end

    // The victim is invalidated at miss time so a reset or abort never leaves a half-filled way valid.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rrPtr_q[s] <= '0;
            end
            lfsr_q <= 16'hACE1;
        end else begin
            if (REPL_POLICY == 1) begin
                lfsr_q <= lfsrNext;
            end
            if (missLatch) begin
                valid_q[reqSet][victim] <= 1'b0;
            end
            if (fillDone) begin
                valid_q[missSet_q][victim_q] <= 1'b1;
                rrPtr_q[missSet_q]           <= rrPtr_q[missSet_q] + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (missLatch) begin
            missTag_q  <= reqTag;
            missSet_q  <= reqSet;
            missWord_q <= reqWord;
            victim_q   <= victim;
        end
        if (beatWrite) begin
            data_q[missSet_q][victim_q][fillOffset] <= bus.MemDataIn;
        end
        if (fillDone) begin
            tag_q[missSet_q][victim_q] <= missTag_q;
        end
    end
endmodule

// File: tb/tb_ucsbece154_icache_cwf.sv
// Randomised directed bench for the critical-word-first icache: two instances (round-robin 4-way/4-word
// and LFSR 2-way/8-word) checked against a tag-level reference model; memory data is a hash of the address.
module tb_ucsbece154_icache_cwf;
    logic        Clk;
    logic        Reset;
    logic        sel;
    logic        re;
    logic [31:0] addr;
    logic        mdr;
    logic [31:0] mdin;
    logic [31:0] salt;
    logic [15:0] mLfsr;

    int compared;
    int mismatched;

    bit          mValid [2][8][4];
    int unsigned mTag   [2][8][4];
    int          mRr    [2][8];

    ucsbece154_icache_cwf_if busA ();
    ucsbece154_icache_cwf_if busB ();

    ucsbece154_icache_cwf #(.NUM_SETS(8), .NUM_WAYS(4), .BLOCK_WORDS(4), .REPL_POLICY(0)) dutA (
        .Clk(Clk), .Reset(Reset), .bus(busA.slave));
    ucsbece154_icache_cwf #(.NUM_SETS(8), .NUM_WAYS(2), .BLOCK_WORDS(8), .REPL_POLICY(1)) dutB (
        .Clk(Clk), .Reset(Reset), .bus(busB.slave));

    assign busA.ReadEnable   = re & ~sel;
    assign busB.ReadEnable   = re & sel;
    assign busA.ReadAddress  = addr;
    assign busB.ReadAddress  = addr;
    assign busA.MemDataIn    = mdin;
    assign busB.MemDataIn    = mdin;
    assign busA.MemDataReady = mdr & ~sel;
    assign busB.MemDataReady = mdr & sel;

    logic [31:0] obsInstr, obsMemAddr;
    logic        obsReady, obsBusy, obsMemReq;
    assign obsInstr   = sel ? busB.Instruction    : busA.Instruction;
    assign obsMemAddr = sel ? busB.MemReadAddress : busA.MemReadAddress;
    assign obsReady   = sel ? busB.Ready          : busA.Ready;
    assign obsBusy    = sel ? busB.Busy           : busA.Busy;
    assign obsMemReq  = sel ? busB.MemReadRequest : busA.MemReadRequest;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference LFSR: seeded by reset, one Fibonacci step per cycle otherwise.
    always @(posedge Clk) begin
        if (Reset) mLfsr <= 16'hACE1;
        else       mLfsr <= {mLfsr[0] ^ mLfsr[2] ^ mLfsr[3] ^ mLfsr[5], mLfsr[15:1]};
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (({a[31:2], 2'b00} ^ salt) * 32'h9E3779B1) + 32'h01234567;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 8; s++) begin
                mRr[d][s] = 0;
                for (int w = 0; w < 4; w++) begin
                    mValid[d][s][w] = 1'b0;
                    mTag[d][s][w]   = 0;
                end
            end
    endtask

    // One fetch; stalls are drawn from [stallMin,stallMax]; abortAt>=0 resets after that many beats.
    task automatic applyStimulus(input logic [31:0] a, input int stallMin, input int stallMax, input int abortAt);
        int unsigned bw, nw, blk, s, t, w, base, victim, n;
        bit hit;
        int d;
        d    = sel ? 1 : 0;
        bw   = sel ? 8 : 4;
        nw   = sel ? 2 : 4;
        blk  = a / (4 * bw);
        s    = blk % 8;
        t    = blk / 8;
        w    = (a / 4) % bw;
        base = blk * 4 * bw;
        hit  = 1'b0;
        for (int i = 0; i < int'(nw); i++)
            if (mValid[d][s][i] && mTag[d][s][i] == t) hit = 1'b1;
        victim = sel ? (mLfsr % nw) : mRr[d][s];
        for (int i = int'(nw) - 1; i >= 0; i--)
            if (!mValid[d][s][i]) victim = i;
        re   = 1'b1;
        addr = a;
        @(posedge Clk); #1;
        if (hit) begin
            checkOutput("hitReady", obsReady, 1);
            checkOutput("hitInstr", obsInstr, memWord(a));
            checkOutput("hitBusy", obsBusy, 0);
            re = 1'b0;
            return;
        end
        checkOutput("missBusy", obsBusy, 1);
        checkOutput("missReq", obsMemReq, 1);
        checkOutput("missAddr", obsMemAddr, {a[31:2], 2'b00});
        checkOutput("missReady", obsReady, 0);
        mValid[d][s][victim] = 1'b0;
        for (int k = 0; k < int'(bw); k++) begin
            n = $urandom_range(stallMax, stallMin);
            repeat (n) begin
                @(posedge Clk); #1;
                checkOutput("stallBusy", obsBusy, 1);
                checkOutput("stallReady", obsReady, 0);
                if (k == 0) checkOutput("stallReq", obsMemReq, 1);
            end
            if (k == abortAt) begin
                Reset = 1'b1;
                re    = 1'b0;
                mdr   = 1'b0;
                @(posedge Clk); #1;
                checkOutput("abortInstr", obsInstr, 0);
                checkOutput("abortReady", obsReady, 0);
                checkOutput("abortBusy", obsBusy, 0);
                checkOutput("abortReq", obsMemReq, 0);
                checkOutput("abortAddr", obsMemAddr, 0);
                Reset = 1'b0;
                clearModel();
                return;
            end
            mdr  = 1'b1;
            mdin = memWord(base + ((w + k) % bw) * 4);
            if (k == int'(bw) - 1) re = 1'b0;
            @(posedge Clk); #1;
            mdr = 1'b0;
            if (k == 0) begin
                checkOutput("earlyReady", obsReady, 1);
                checkOutput("earlyInstr", obsInstr, memWord(a));
                checkOutput("earlyReqLow", obsMemReq, 0);
            end else begin
                checkOutput("fillReady", obsReady, 0);
            end
            if (k == int'(bw) - 1) begin
                checkOutput("doneBusy", obsBusy, 0);
                mValid[d][s][victim] = 1'b1;
                mTag[d][s][victim]   = t;
                mRr[d][s]            = (mRr[d][s] + 1) % int'(nw);
            end else begin
                checkOutput("fillBusy", obsBusy, 1);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        salt  = $urandom;
        sel   = 1'b0;
        re    = 1'b0;
        addr  = '0;
        mdr   = 1'b0;
        mdin  = '0;
        Reset = 1'b1;
        clearModel();
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("rstReadyA", busA.Ready, 0);
        checkOutput("rstBusyA", busA.Busy, 0);
        checkOutput("rstInstrA", busA.Instruction, 0);
        checkOutput("rstReqA", busA.MemReadRequest, 0);
        checkOutput("rstAddrA", busA.MemReadAddress, 0);
        checkOutput("rstBusyB", busB.Busy, 0);
        Reset = 1'b0;

        // Cold miss with critical word 0x48, then back-to-back hits in the filled block.
        applyStimulus(32'h0000_0048, 0, 0, -1);
        applyStimulus(32'h0000_0040, 0, 0, -1);
        applyStimulus(32'h0000_0044, 0, 0, -1);
        applyStimulus(32'h0000_004C, 0, 0, -1);

        // Stray beat while idle must be ignored.
        mdr  = 1'b1;
        mdin = 32'hDEAD_BEEF;
        @(posedge Clk); #1;
        mdr = 1'b0;
        checkOutput("idleBeatBusy", obsBusy, 0);
        checkOutput("idleBeatReady", obsReady, 0);
        applyStimulus(32'h0000_0044, 0, 0, -1);

        // Five blocks in set 0: fifth evicts way 0 round-robin.
        for (int i = 0; i < 5; i++) applyStimulus(32'h2000 + i * 128, 0, 1, -1);
        applyStimulus(32'h2000 + 1 * 128 + 4, 0, 0, -1);
        applyStimulus(32'h2000 + 8, 0, 0, -1);

        // Fixed three-cycle stalls between beats.
        applyStimulus(32'h0000_0504, 3, 3, -1);
        applyStimulus(32'h0000_0508, 0, 0, -1);

        // Reset after two beats, then refetch.
        applyStimulus(32'h0000_0608, 0, 0, 2);
        applyStimulus(32'h0000_0608, 0, 1, -1);
        applyStimulus(32'h0000_060C, 0, 0, -1);
        applyStimulus(32'h0000_0048, 0, 0, -1);

        for (int i = 0; i < 40; i++)
            applyStimulus(32'h4000 + $urandom_range(0, 255) * 4, 0, 2, -1);

        // LFSR instance: three blocks conflicting in one set, then random revisits.
        sel = 1'b1;
        @(posedge Clk); #1;
        for (int i = 0; i < 3; i++) applyStimulus(32'h3000 + i * 256 + 4 * i, 0, 1, -1);
        for (int i = 0; i < 20; i++)
            applyStimulus(32'h3000 + $urandom_range(0, 2) * 256 + $urandom_range(0, 7) * 4, 0, 1, -1);
        for (int i = 0; i < 20; i++)
            applyStimulus(32'h5000 + $urandom_range(0, 511) * 4, 0, 2, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
